// File: rtl/frv_core_mem_arbiter_pkg.sv
// rtl/frv_core_mem_arbiter_pkg.sv - shared types and helpers for the fetch/LSU memory arbiter
package frv_core_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_GNT_I = 2'd1,
        ARB_GNT_D = 2'd2
    } arb_state_t;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_I    = 2'b01;
    localparam logic [1:0] GNT_D    = 2'b10;

    localparam int RUN_CNT_W = 4;
    localparam logic [RUN_CNT_W-1:0] RUN_ONE = RUN_CNT_W'(1);

    function automatic logic [RUN_CNT_W-1:0] run_cnt_inc(
        input logic [RUN_CNT_W-1:0] cnt,
        input logic [RUN_CNT_W-1:0] limit
    );
        return (cnt >= limit) ? limit : cnt + RUN_ONE;
    endfunction

endpackage

// File: rtl/frv_core_mem_arb_pick.sv
// rtl/frv_core_mem_arb_pick.sv - combinational next-grant decision
// FRV_MEM_ARB_RR_EN selects round-robin; otherwise dmem priority with a fetch starvation limit.
module frv_core_mem_arb_pick
    import frv_core_mem_arbiter_pkg::*;
(
    input  logic       i_req,
    input  logic       d_req,
`ifdef FRV_MEM_ARB_RR_EN
    input  logic       rr_ptr,
`else
    input  logic       run_max,
`endif
    output logic [1:0] gnt_next
);

    always_comb begin
        gnt_next = GNT_NONE;
`ifdef FRV_MEM_ARB_RR_EN
        if (i_req && d_req) begin
            gnt_next = rr_ptr ? GNT_D : GNT_I;
        end else if (i_req) begin
            gnt_next = GNT_I;
        end else if (d_req) begin
            gnt_next = GNT_D;
        end
`else
        // fetch only jumps the queue once the LSU has used up its run
        if (i_req && d_req) begin
            gnt_next = run_max ? GNT_I : GNT_D;
        end else if (i_req) begin
            gnt_next = GNT_I;
        end else if (d_req) begin
            gnt_next = GNT_D;
        end
`endif
    end

endmodule

// File: rtl/frv_core_mem_arbiter.sv
// rtl/frv_core_mem_arbiter.sv - shares one memory bus between fetch and load/store ports
// Optional FRV_MEM_ARB_RR_EN: round-robin pick instead of dmem priority with starvation limit.
module frv_core_mem_arbiter
    import frv_core_mem_arbiter_pkg::*;
#(
    parameter int unsigned D_MAX_RUN = 4
) (
    input  logic        g_clk,
    input  logic        g_reset,

    input  logic        imem_cen,
    input  logic        imem_wen,
    input  logic [3:0]  imem_strb,
    input  logic [31:0] imem_addr,
    input  logic [31:0] imem_wdata,
    output logic        imem_stall,
    output logic        imem_error,
    output logic [31:0] imem_rdata,

    input  logic        dmem_cen,
    input  logic        dmem_wen,
    input  logic [3:0]  dmem_strb,
    input  logic [31:0] dmem_addr,
    input  logic [31:0] dmem_wdata,
    output logic        dmem_stall,
    output logic        dmem_error,
    output logic [31:0] dmem_rdata,

    output logic        mem_cen,
    output logic        mem_wen,
    output logic [3:0]  mem_strb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_stall,
    input  logic        mem_error,
    input  logic [31:0] mem_rdata,

    output logic [1:0]  arb_gnt
);

    arb_state_t state;
    logic [1:0] gnt_next;
    logic       take_grant;

    assign take_grant = (state == ARB_IDLE) && (gnt_next != GNT_NONE);

`ifdef FRV_MEM_ARB_RR_EN
    logic rr_ptr;

    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            rr_ptr <= 1'b0;
        end else if (take_grant && imem_cen && dmem_cen) begin
            rr_ptr <= ~rr_ptr;
        end
    end

    frv_core_mem_arb_pick u_pick (
        .i_req    (imem_cen),
        .d_req    (dmem_cen),
        .rr_ptr   (rr_ptr),
        .gnt_next (gnt_next)
    );
`else
    localparam logic [RUN_CNT_W-1:0] RUN_LIMIT = RUN_CNT_W'(D_MAX_RUN);

    logic [RUN_CNT_W-1:0] run_cnt;

    // counts LSU grants taken while fetch is waiting; any fetch idle cycle forgives the run
    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            run_cnt <= '0;
        end else if (!imem_cen) begin
            run_cnt <= '0;
        end else if (take_grant && (gnt_next == GNT_I)) begin
            run_cnt <= '0;
        end else if (take_grant && (gnt_next == GNT_D)) begin
            run_cnt <= run_cnt_inc(run_cnt, RUN_LIMIT);
        end
    end

    frv_core_mem_arb_pick u_pick (
        .i_req    (imem_cen),
        .d_req    (dmem_cen),
        .run_max  (run_cnt == RUN_LIMIT),
        .gnt_next (gnt_next)
    );
`endif

    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            state   <= ARB_IDLE;
            arb_gnt <= GNT_NONE;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (gnt_next == GNT_I) begin
                        state   <= ARB_GNT_I;
                        arb_gnt <= GNT_I;
                    end else if (gnt_next == GNT_D) begin
                        state   <= ARB_GNT_D;
                        arb_gnt <= GNT_D;
                    end
                end
                ARB_GNT_I: begin
                    // completion or an abandoned request both release the bus
                    if (!imem_cen || !mem_stall) begin
                        state   <= ARB_IDLE;
                        arb_gnt <= GNT_NONE;
                    end
                end
                ARB_GNT_D: begin
                    if (!dmem_cen || !mem_stall) begin
                        state   <= ARB_IDLE;
                        arb_gnt <= GNT_NONE;
                    end
                end
                default: begin
                    state   <= ARB_IDLE;
                    arb_gnt <= GNT_NONE;
                end
            endcase
        end
    end

    always_comb begin
        mem_cen    = 1'b0;
        mem_wen    = 1'b0;
        mem_strb   = 4'h0;
        mem_addr   = 32'h0;
        mem_wdata  = 32'h0;
        imem_stall = imem_cen;
        imem_error = 1'b0;
        imem_rdata = 32'h0;
        dmem_stall = dmem_cen;
        dmem_error = 1'b0;
        dmem_rdata = 32'h0;
        case (state)
            ARB_GNT_I: begin
                mem_cen    = imem_cen;
                mem_wen    = imem_wen;
                mem_strb   = imem_strb;
                mem_addr   = imem_addr;
                mem_wdata  = imem_wdata;
                imem_stall = mem_stall;
                imem_error = mem_error;
                imem_rdata = mem_rdata;
            end
            ARB_GNT_D: begin
                mem_cen    = dmem_cen;
                mem_wen    = dmem_wen;
                mem_strb   = dmem_strb;
                mem_addr   = dmem_addr;
                mem_wdata  = dmem_wdata;
                dmem_stall = mem_stall;
                dmem_error = mem_error;
                dmem_rdata = mem_rdata;
            end
            default: begin
            end
        endcase
    end

endmodule
